// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared AES decrypt-path definitions:
//     gf_xtime       multiply a byte by x (0x02) in GF(2^8), poly 0x11B
//     gf_mul         multiply a byte by a small constant (09/0b/0d/0e)
//     aes_state_t    128-bit state viewed as [column][byte][bit]. Column 0 is
//                    the most significant word, and byte a0 is its top byte.
//     inv_mc_state_e FSM states of the iterative InvMixColumns engine
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [3:0][3:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } inv_mc_state_e;

    // Doubling in GF(2^8): shift left, then fold the carry back in with 0x1B.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add product. With a constant multiplier the unused branches
    // fold away, leaving a few xtime stages and XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] pow;
        acc = 8'h00;
        pow = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                acc = acc ^ pow;
            end
            pow = gf_xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mixcolumn32.sv
// ---------------------------------------------------------------------------
// inv_mixcolumn32
//   Combinational InvMixColumns for one 32-bit column.
//   Ports:
//     col_i  in  32  column {a0,a1,a2,a3}, a0 in bits [31:24]
//     col_o  out 32  transformed column {b0,b1,b2,b3}, same layout
// ---------------------------------------------------------------------------
module inv_mixcolumn32
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Each output byte uses the circulant row {0e,0b,0d,09}, rotated one
    // position to the right for each successive byte.
    always_comb begin
        col_o[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        col_o[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        col_o[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        col_o[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end

endmodule

// File: rtl/inv_mixcolumn_seq.sv
// ---------------------------------------------------------------------------
// inv_mixcolumn_seq
//   Iterative InvMixColumns engine. It processes COLS_PER_CYCLE (1, 2 or 4)
//   columns per clock through shared column transforms.
//   Ports:
//     clk        in   1    clock
//     rst_n      in   1    asynchronous active-low reset
//     clear      in   1    synchronous abort back to IDLE
//     in_valid   in   1    state_in valid
//     in_ready   out  1    high only in IDLE
//     state_in   in   128  input state, column c = bits [127-32c -: 32]
//     out_valid  out  1    state_out valid; held until out_ready
//     out_ready  in   1    consumer accepts state_out
//     state_out  out  128  InvMixColumns(state_in)
//     busy       out  1    high in CALC or DONE
// ---------------------------------------------------------------------------
module inv_mixcolumn_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadParam
        $error("inv_mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    inv_mc_state_e state_q;
    logic [1:0]    col_q;
    aes_state_t    work_q;
    aes_state_t    work_d;
    aes_state_t    outState_q;

    logic [1:0]    colIdx [COLS_PER_CYCLE];
    logic [31:0]   colIn  [COLS_PER_CYCLE];
    logic [31:0]   colOut [COLS_PER_CYCLE];

    // Column mux: group member g handles column col_q+g. In the packed view
    // column 0 is the top word, so column c sits at index 3-c, which is ~c
    // for a 2-bit value.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gCol
        assign colIdx[g] = col_q + 2'(g);
        assign colIn[g]  = work_q[~colIdx[g]];

        inv_mixcolumn32 uCol (
            .col_i (colIn[g]),
            .col_o (colOut[g])
        );
    end

    // Column demux: write the transformed group back in place and leave the
    // other columns unchanged. On the last group, work_d is the complete
    // result, so it also feeds the output register directly.
    always_comb begin
        work_d = work_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_d[~colIdx[g]] = colOut[g];
        end
    end

    // Main FSM, column counter, work register and output register.
    // clear beats every handshake. It leaves the output register alone so
    // that state_out keeps its last value. Reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            work_q     <= '0;
            outState_q <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= state_in;
                        col_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    work_q <= work_d;
                    col_q  <= col_q + COL_STEP;
                    if (col_q == LAST_COL) begin
                        outState_q <= work_d;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode straight from the state register, so they are
    // glitch-free and change only on a clock edge or a reset.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign state_out = outState_q;

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_mixcolumn_seq
//   Self-checking bench for inv_mixcolumn_seq. It uses known-answer vectors,
//   handshake timing, backpressure, abort and async reset cases, plus random
//   states compared against a behavioural GF(2^8) matrix model.
// ---------------------------------------------------------------------------
module tb_inv_mixcolumn_seq;

    parameter int N = 1;
    localparam int LAT    = 4 / N + 1;
    localparam int PERIOD = 4 / N + 2;
    localparam int NRAND  = 2000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] state_out;
    logic         busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    inv_mixcolumn_seq #(.COLS_PER_CYCLE(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // Plain shift-and-add GF(2^8) multiply with reduction by 0x11B.
    function automatic logic [7:0] gmulRef(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        end
        return prod[7:0];
    endfunction

    // Circulant matrix product over every column. The matrix row is given by
    // coef, and entry (r,k) is coef[(k-r) mod 4].
    function automatic logic [127:0] matMulRef(input logic [127:0] s, input logic [31:0] coefWord);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [31:0]  col;
        r = '0;
        for (int k = 0; k < 4; k++) coef[k] = coefWord[31 - 8 * k -: 8];
        for (int c = 0; c < 4; c++) begin
            col = s[127 - 32 * c -: 32];
            for (int k = 0; k < 4; k++) a[k] = col[31 - 8 * k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmulRef(coef[(k - row + 4) % 4], a[k]);
                r[127 - 32 * c - 8 * row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] invMixRef(input logic [127:0] s);
        return matMulRef(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] mixRef(input logic [127:0] s);
        return matMulRef(s, 32'h02030101);
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one state and wait for its result. When doAccept is 0, the block
    // is left in DONE with out_ready low, and the task returns at a negedge.
    task automatic applyStimulus(input logic [127:0] s, input bit doAccept,
                                 output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("wait_in_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        state_in = s;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        if (!out_valid) checkOutput("wait_out_valid", 128'(out_valid), 128'd1);
        res = state_out;
        if (doAccept) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] lastOut;
        logic [127:0] s;
        logic [127:0] vec [3];
        logic [127:0] got [3];
        int           accCyc [3];
        int           lat;
        int           nIn;
        int           nRes;
        int           cyc;
        bit           acc;

        // Reset state
        #2;
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_state_out", state_out, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'd1);

        // Known-answer columns, including the two fixed points
        applyStimulus(128'h046681e5_8e4da1bc_01010101_c6c6c6c6, 1'b1, res, lat);
        checkOutput("kat_columns", res, 128'hd4bf5d30_db135345_01010101_c6c6c6c6);
        checkOutput("kat_columns_latency", 128'(lat), 128'(LAT));

        // Full known-answer state
        applyStimulus(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, res, lat);
        checkOutput("kat_state", res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        checkOutput("kat_state_latency", 128'(lat), 128'(LAT));
        #1;
        checkOutput("kat_idle_after", 128'({in_ready, busy, out_valid}), 128'b100);

        // Backpressure: hold out_ready low for 10 cycles in DONE
        s = 128'h00112233_44556677_8899aabb_ccddeeff;
        applyStimulus(s, 1'b0, res, lat);
        checkOutput("bp_result", res, invMixRef(s));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
            checkOutput("bp_state_out", state_out, res);
            checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
            checkOutput("bp_busy", 128'(busy), 128'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_in_ready_after", 128'(in_ready), 128'd1);
        checkOutput("bp_out_valid_after", 128'(out_valid), 128'd0);

        // Back-to-back: in_valid held high, out_ready high
        for (int i = 0; i < 3; i++) vec[i] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        state_in  = vec[0];
        out_ready = 1'b1;
        nIn = 0;
        nRes = 0;
        cyc = 0;
        while ((nIn < 3 || nRes < 3) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            acc = in_ready && in_valid;
            if (out_valid && nRes < 3) begin
                got[nRes] = state_out;
                nRes++;
            end
            if (acc) begin
                accCyc[nIn] = cyc;
                nIn++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (nIn < 3) state_in = vec[nIn];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_accepts", 128'(nIn), 128'd3);
        checkOutput("b2b_results", 128'(nRes), 128'd3);
        if (nIn == 3 && nRes == 3) begin
            for (int i = 0; i < 3; i++) checkOutput("b2b_data", got[i], invMixRef(vec[i]));
            checkOutput("b2b_spacing01", 128'(accCyc[1] - accCyc[0]), 128'(PERIOD));
            checkOutput("b2b_spacing12", 128'(accCyc[2] - accCyc[1]), 128'(PERIOD));
        end
        lastOut = got[2];

        // Abort: pulse clear during the second cycle after the accept edge
        @(negedge clk);
        in_valid = 1'b1;
        state_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ready", 128'(in_ready), 128'd1);
        checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_state_out_kept", state_out, lastOut);
        s = 128'h3243f6a8_885a308d_313198a2_e0370734;
        applyStimulus(s, 1'b1, res, lat);
        checkOutput("abort_next", res, invMixRef(s));
        checkOutput("abort_next_latency", 128'(lat), 128'(LAT));

        // clear and in_valid together in IDLE: nothing is captured
        @(negedge clk);
        in_valid = 1'b1;
        clear = 1'b1;
        state_in = 128'h11111111_22222222_33333333_44444444;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        checkOutput("clear_in_idle_busy", 128'(busy), 128'd0);
        checkOutput("clear_in_idle_in_ready", 128'(in_ready), 128'd1);

        // Async reset while in DONE, checked between clock edges
        s = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
        applyStimulus(s, 1'b0, res, lat);
        checkOutput("arst_pre_result", res, invMixRef(s));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("arst_state_out", state_out, 128'd0);
        checkOutput("arst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("arst_in_ready", 128'(in_ready), 128'd1);

        // Random states: compare against the model and round-trip through MixColumns
        for (int i = 0; i < NRAND; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(s, 1'b1, res, lat);
            checkOutput("rand_invmix", res, invMixRef(s));
            checkOutput("rand_roundtrip", mixRef(res), s);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
